// File: rtl/pc_gen_pkg.sv
// Shared constants and next-PC source encoding for the program-counter generator
// and the control unit that drives it.
package pc_gen_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned STEP_DEF     = 4;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    NPC_INC,
    NPC_LOAD,
    NPC_RET
  } npc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, same-cycle replace of the top,
// and sticky overflow/underflow flags. The oldest entry is overwritten when full.
module pc_ras #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            unf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, top_idx, wr_idx;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            do_pop, wr_en;

  assign top_idx = wptr_q - AW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = wptr_q;
    if (pop && empty) unf_d = 1'b1;
    if (push && do_pop) begin
      // Pop then push nets out to overwriting the top in place.
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (do_pop) begin
      wptr_d  = top_idx;
      count_d = count_q - (AW + 1)'(1);
    end else if (push) begin
      wr_en  = 1'b1;
      wptr_d = wptr_q + AW'(1);
      if (full) ovf_d = 1'b1;
      else      count_d = count_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Contents need no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter register with next-PC source mux (increment / load / return).
// Define PC_GEN_RAS_EN to include the return-address stack; otherwise call/ret are ignored.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter int unsigned     NSRC      = 4,
  parameter int unsigned     STEP      = STEP_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int unsigned     RAS_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [$clog2(NSRC)-1:0] sel,
  input  logic [NSRC*XLEN-1:0]    src_din,
  input  logic                    call,
  input  logic                    ret,
  output logic [XLEN-1:0]         pc,
  output logic [XLEN-1:0]         pc_next,
  output logic                    ras_empty,
  output logic                    ras_full,
  output logic                    ras_ovf,
  output logic                    ras_unf
);

  logic [XLEN-1:0] pc_q, pc_inc, load_val, ras_top;
  logic            ret_ok;
  npc_src_e        npc_src;

  assign pc_inc = pc_q + XLEN'(STEP);

`ifdef PC_GEN_RAS_EN
  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (en & call),
    .pop   (en & ret),
    .din   (pc_inc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

  assign ret_ok = ret & ~ras_empty;
`else
  logic unused_ras;

  assign unused_ras = call ^ ret;
  assign ras_top    = '0;
  assign ret_ok     = 1'b0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_ovf    = 1'b0;
  assign ras_unf    = 1'b0;
`endif

  // Out-of-range selects fall through to source 0.
  always_comb begin
    load_val = src_din[XLEN-1:0];
    for (int unsigned i = 1; i < NSRC; i++) begin
      if (32'(sel) == i) load_val = src_din[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    if (ret_ok)    npc_src = NPC_RET;
    else if (load) npc_src = NPC_LOAD;
    else           npc_src = NPC_INC;
  end

  always_comb begin
    pc_next = pc_q;
    if (en) begin
      case (npc_src)
        NPC_RET:  pc_next = ras_top;
        NPC_LOAD: pc_next = load_val;
        default:  pc_next = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_next;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, RAS corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pc_gen;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NSRC     = 3;
  localparam int unsigned DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h100;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n, en, load, call, ret;
  logic [1:0]           sel;
  logic [NSRC*XLEN-1:0] src_din;
  logic [XLEN-1:0]      pc, pc_next;
  logic                 ras_empty, ras_full, ras_ovf, ras_unf;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pc_m;
  logic [31:0] ras_q[$];
  bit          ovf_m, unf_m;

  typedef struct {
    bit          en;
    bit          load;
    logic [1:0]  sel;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  pc_gen #(
    .XLEN      (XLEN),
    .NSRC      (NSRC),
    .STEP      (4),
    .RESET_PC  (RESET_PC),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .sel       (sel),
    .src_din   (src_din),
    .call      (call),
    .ret       (ret),
    .pc        (pc),
    .pc_next   (pc_next),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("pc", pc, pc_m);
    chk("ras_empty", 32'(ras_empty), 32'(!RAS_EN || ras_q.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(RAS_EN && ras_q.size() == DEPTH));
    chk("ras_ovf", 32'(ras_ovf), 32'(ovf_m));
    chk("ras_unf", 32'(ras_unf), 32'(unf_m));
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    src_din[i*32 +: 32] = v;
  endtask

  // Asserts reset between edges and checks that it acts without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    pc_m = RESET_PC;
    ras_q.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit e, input bit l, input logic [1:0] s, input bit c, input bit r);
    logic [31:0] exp_next;
    int          idx;
    en = e; load = l; sel = s; call = c; ret = r;
    #1;
    idx = (int'(s) < NSRC) ? int'(s) : 0;
    if (!e)                                     exp_next = pc_m;
    else if (RAS_EN && r && ras_q.size() > 0)   exp_next = ras_q[ras_q.size()-1];
    else if (l)                                 exp_next = src_din[idx*32 +: 32];
    else                                        exp_next = pc_m + 32'd4;
    chk("pc_next", pc_next, exp_next);
    @(posedge clk);
    #1;
    if (e && RAS_EN) begin
      if (r && ras_q.size() == 0) unf_m = 1'b1;
      if (c && r && ras_q.size() > 0) begin
        ras_q[ras_q.size()-1] = pc_m + 32'd4;
      end else if (r && ras_q.size() > 0) begin
        void'(ras_q.pop_back());
      end else if (c) begin
        if (ras_q.size() == DEPTH) begin
          ovf_m = 1'b1;
          void'(ras_q.pop_front());
        end
        ras_q.push_back(pc_m + 32'd4);
      end
    end
    pc_m = exp_next;
    check_state();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; sel = '0; call = 1'b0; ret = 1'b0;
    src_din = '0;
    set_src(0, 32'h1000);
    set_src(1, 32'h2000);
    set_src(2, 32'h4000);
    pc_m = RESET_PC;
    ovf_m = 1'b0;
    unf_m = 1'b0;

    vecs[0] = '{en: 1, load: 0, sel: 2'd0, exp_pc: 32'h104};
    vecs[1] = '{en: 1, load: 0, sel: 2'd0, exp_pc: 32'h108};
    vecs[2] = '{en: 1, load: 0, sel: 2'd0, exp_pc: 32'h10C};
    vecs[3] = '{en: 0, load: 1, sel: 2'd2, exp_pc: 32'h10C};
    vecs[4] = '{en: 1, load: 1, sel: 2'd2, exp_pc: 32'h4000};
    vecs[5] = '{en: 1, load: 1, sel: 2'd3, exp_pc: 32'h1000};
    vecs[6] = '{en: 1, load: 1, sel: 2'd1, exp_pc: 32'h2000};
    vecs[7] = '{en: 1, load: 0, sel: 2'd0, exp_pc: 32'h2004};

    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("reset_pc", pc, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].load, vecs[i].sel, 1'b0, 1'b0);
      chk($sformatf("tbl_pc[%0d]", i), pc, vecs[i].exp_pc);
    end

    // Mid-run asynchronous reset.
    @(posedge clk);
    #1;
    do_reset();
    chk("async_reset_pc", pc, 32'h100);

    // Call with jump, then return.
    set_src(0, 32'h200);
    cycle(1, 1, 2'd0, 0, 0);
    cycle(1, 1, 2'd2, 1, 0);
    chk("call_pc", pc, 32'h4000);
    cycle(1, 0, 2'd0, 0, 1);
    chk("ret_pc", pc, RAS_EN ? 32'h204 : 32'h4004);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    // Stall with load and ret asserted, then release.
    cycle(1, 1, 2'd1, 1, 0);
    cycle(0, 1, 2'd2, 0, 1);
    cycle(0, 1, 2'd2, 0, 1);
    chk("stall_pc", pc, 32'h2000);
    cycle(1, 1, 2'd2, 0, 1);
    chk("stall_release", pc, RAS_EN ? 32'h208 : 32'h4000);

    // Nine calls into an eight-deep stack, then drain past empty.
    @(posedge clk);
    #1;
    do_reset();
    repeat (9) cycle(1, 0, 2'd0, 1, 0);
    chk("ovf_full", 32'(ras_full), 32'(RAS_EN));
    chk("ovf_flag", 32'(ras_ovf), 32'(RAS_EN));
    repeat (8) cycle(1, 0, 2'd0, 0, 1);
    chk("drain_pc", pc, RAS_EN ? 32'h108 : 32'h144);
    cycle(1, 0, 2'd0, 0, 1);
    chk("unf_flag", 32'(ras_unf), 32'(RAS_EN));
    chk("unf_pc", pc, RAS_EN ? 32'h10C : 32'h148);

    // Wrap from the top of the address space.
    set_src(0, 32'hFFFF_FFFC);
    cycle(1, 1, 2'd0, 0, 0);
    cycle(1, 0, 2'd0, 0, 0);
    chk("wrap_pc", pc, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) set_src(int'($urandom_range(0, NSRC-1)), $urandom);
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
